alu_mdu: RTL and testbench

//  Parametrised, sequential execute unit for the RV core: the full RV32I ALU op set plus the RV M-extension
//  (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), with a valid/ready handshake on both sides.

---
 rtl/alu_mdu.sv | 178 +++++++++++++++++
 tb/tb_alu_mdu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Sequential RV32/64 execute unit: single-cycle RV32I ALU ops plus iterative
// (1 bit/cycle) M-extension multiply/divide behind valid/ready handshakes.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // Base op codes are {funct7[5], funct3}; anything unlisted yields zero.
  function automatic logic [XLEN-1:0] f_alu(input logic [3:0] sel,
                                            input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    logic [SHAMT_W-1:0] sh;
    sh = y[SHAMT_W-1:0];
    case (sel)
      4'b0000: f_alu = x + y;
      4'b1000: f_alu = x - y;
      4'b0001: f_alu = x << sh;
      4'b0010: f_alu = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      4'b0011: f_alu = {{(XLEN-1){1'b0}}, (x < y)};
      4'b0100: f_alu = x ^ y;
      4'b0101: f_alu = x >> sh;
      4'b1101: f_alu = $unsigned($signed(x) >>> sh);
      4'b0110: f_alu = x | y;
      4'b0111: f_alu = x & y;
      default: f_alu = '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] x, input logic neg);
    f_mag = neg ? (~x + 1'b1) : x;
  endfunction

  logic [1:0]         r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;
  logic [XLEN-1:0]    r_opd;
  logic               r_neg;
  logic               r_rneg;
  logic [1:0]         r_fn;
  logic [XLEN-1:0]    r_result;

  logic               w_accept;
  logic               w_mop;
  logic               w_div_s;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_a_mag;
  logic [XLEN-1:0]    w_b_mag;
  logic               w_b_zero;
  logic               w_ovf;
  logic [XLEN:0]      w_sum;
  logic [XLEN-1:0]    w_mul_hi;
  logic [XLEN-1:0]    w_mul_lo;
  logic [XLEN:0]      w_rsh;
  logic [XLEN:0]      w_diff;
  logic               w_ge;
  logic [XLEN-1:0]    w_div_hi;
  logic [XLEN-1:0]    w_div_lo;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_final;
  logic               w_last;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL) | (r_state == S_DIV);
  assign result    = r_result;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = busy & (r_cnt == SHAMT_W'(XLEN-1));

  // Operand signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u, DIV/REM signed.
  always_comb begin
    w_mop    = op[4] & ~op[3];
    w_div_s  = ~op[0];
    w_a_neg  = (op[2] ? w_div_s : (op[1:0] != 2'b11)) & a[XLEN-1];
    w_b_neg  = (op[2] ? w_div_s : ~op[1]) & b[XLEN-1];
    w_a_mag  = f_mag(a, w_a_neg);
    w_b_mag  = f_mag(b, w_b_neg);
    w_b_zero = (b == '0);
    w_ovf    = w_div_s & (a == MIN_INT) & (b == {XLEN{1'b1}});
  end

  // One shift-add multiply step and one restoring divide step, sharing r_hi/r_lo.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_mul_hi = w_sum[XLEN:1];
    w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
    w_rsh    = {r_hi, r_lo[XLEN-1]};
    w_diff   = w_rsh - {1'b0, r_opd};
    w_ge     = ~w_diff[XLEN];
    w_div_hi = w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
    w_div_lo = {r_lo[XLEN-2:0], w_ge};
    w_prod   = {w_mul_hi, w_mul_lo};
    if (r_neg) w_prod = ~w_prod + 1'b1;
    if (r_state == S_MUL)
      w_final = (r_fn == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (r_fn[1])
      w_final = f_mag(w_div_hi, r_rneg);
    else
      w_final = f_mag(w_div_lo, r_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_fn     <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (busy) begin
      r_hi  <= (r_state == S_MUL) ? w_mul_hi : w_div_hi;
      r_lo  <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
      r_cnt <= r_cnt + SHAMT_W'(1);
      if (w_last) begin
        r_state  <= S_DONE;
        r_result <= w_final;
        r_cnt    <= '0;
      end
    end else if (w_accept) begin
      r_cnt <= '0;
      r_fn  <= op[1:0];
      if (!w_mop) begin
        r_result <= op[4] ? '0 : f_alu(op[3:0], a, b);
        r_state  <= S_DONE;
      end else if (!op[2]) begin
        r_hi    <= '0;
        r_lo    <= w_b_mag;
        r_opd   <= w_a_mag;
        r_neg   <= w_a_neg ^ w_b_neg;
        r_state <= S_MUL;
      end else if (w_b_zero) begin
        r_result <= op[1] ? a : {XLEN{1'b1}};
        r_state  <= S_DONE;
      end else if (w_ovf) begin
        r_result <= op[1] ? '0 : a;
        r_state  <= S_DONE;
      end else begin
        r_hi    <= '0;
        r_lo    <= w_a_mag;
        r_opd   <= w_b_mag;
        r_neg   <= w_a_neg ^ w_b_neg;
        r_rneg  <= w_a_neg;
        r_state <= S_DIV;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32): directed literal cases plus a
// randomized handshake run checked every cycle against a transaction-level model.
module tb_alu_mdu;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    if (!o[4]) begin
      case (o[3:0])
        4'b0000: return x + y;
        4'b1000: return x - y;
        4'b0001: return x << y[4:0];
        4'b0010: return (sx < sy) ? 32'd1 : 32'd0;
        4'b0011: return (ux < uy) ? 32'd1 : 32'd0;
        4'b0100: return x ^ y;
        4'b0101: return x >> y[4:0];
        4'b1101: begin p = sx >>> y[4:0]; return p[31:0]; end
        4'b0110: return x | y;
        4'b0111: return x & y;
        default: return 32'd0;
      endcase
    end
    if (o[3]) return 32'd0;
    case (o[2:0])
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin pu = {32'd0, x} * {32'd0, y}; return pu[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'b101: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[4] || o[3]) return 1;
    if (!o[2]) return 33;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    logic [4:0] base_ops [10] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011,
                                  5'b00100, 5'b00101, 5'b01101, 5'b00110, 5'b00111};
    case ($urandom % 4)
      0, 1: return {2'b10, 3'($urandom % 8)};
      2: return base_ops[$urandom % 10];
      default: return 5'($urandom % 32);
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  bit   m_done;
  bit   m_rdy;

  // Compare process: outstanding op queue with accept-edge timestamps.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset result", result, 0);
      chk("reset in_ready", in_ready, 1);
      q.delete();
    end else begin
      m_done = 1'b0;
      if (q.size() != 0) m_done = ((cyc - q[0].acc + 1) >= q[0].lat);
      m_rdy = (q.size() == 0) || (m_done && out_ready);
      chk("out_valid", out_valid, m_done);
      chk("busy", busy, (q.size() != 0) && !m_done);
      chk("in_ready", in_ready, m_rdy);
      if (m_done) chk("result", result, q[0].res);
      if (flush) begin
        q.delete();
      end else begin
        if (m_done && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back('{model(op, a, b), lat_of(op, a, b), cyc + 1});
      end
    end
  end

  task automatic run_lit(input string name, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n;
    @(posedge clk); #1;
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, n, lat);
    chk(name, result, exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  bit drv_acc;
  int issued;
  int rises;

  initial begin
    chk("model MULHSU -1*2", model(OP_MULHSU, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    chk("model REM -7,2", model(OP_REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    chk("model DIVU 100,7", model(OP_DIVU, 32'd100, 32'd7), 32'd14);
    chk("model lat DIV/0", lat_of(OP_DIV, 32'd5, 32'd0), 1);

    #2 rst_n = 1'b0;
    #1;
    chk("init out_valid", out_valid, 0);
    chk("init result", result, 0);
    chk("init busy", busy, 0);
    chk("init in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_lit("ADD 5,7", OP_ADD, 32'd5, 32'd7, 32'd12, 1);
    run_lit("SRA", OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1);
    run_lit("SLTU", OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, 1);
    run_lit("MUL", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_lit("MULH", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_lit("MULHU", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_lit("DIV -7,2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_lit("REM -7,2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_lit("DIVU 100,7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_lit("REMU 100,7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_lit("DIV 5,0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_lit("REMU 9,0", OP_REMU, 32'd9, 32'd0, 32'd9, 1);
    run_lit("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_lit("REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_lit("unknown base", 5'b01001, 32'd3, 32'd4, 32'd0, 1);
    run_lit("M op3 set", 5'b11000, 32'd3, 32'd4, 32'd0, 1);

    // Consumer stall in DONE, then release lets the waiting op in on the same edge.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    op = OP_SUB; a = 32'd10; b = 32'd3;
    for (int k = 0; k < 5; k++) begin
      chk("stall out_valid", out_valid, 1);
      chk("stall result", result, 32'd3);
      chk("stall in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release next valid", out_valid, 1);
    chk("release next result", result, 32'd7);
    in_valid = 1'b0;

    // Flush ten cycles into a multiply, with a competing in_valid.
    @(posedge clk); #1;
    op = OP_MUL; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; op = OP_ADD;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush out_valid", out_valid, 0);
    rises = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) rises++;
    end
    chk("flush no result", rises, 0);
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush drops in_valid", out_valid, 0);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("div busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst result", result, 0);
    chk("async rst in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic with consumer back-pressure and occasional flushes.
    issued = 0;
    for (int it = 0; it < 40000 && issued < 400; it++) begin
      @(negedge clk);
      drv_acc = in_valid && in_ready && !flush;
      if (drv_acc) issued++;
      @(posedge clk); #1;
      flush = ($urandom % 64 == 0);
      out_ready = ($urandom % 4 != 0);
      if (drv_acc || !in_valid) begin
        in_valid = ($urandom % 3 != 0);
        op = rnd_op();
        a = rnd_val();
        b = rnd_val();
      end
    end
    chk("random ops accepted", issued, 400);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("drained out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
